// File: rtl/fpcvt_seq_if.sv
// Handshake and result bus between the sample source/consumer and fpcvt_seq.
interface fpcvt_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [2:0]  out_exp;
    logic [3:0]  out_sig;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig
    );
endinterface

// File: rtl/fpcvt_seq.sv
// fpcvt_seq: converts a 12-bit two's-complement sample to an 8-bit float
// (1 sign, 3 exponent, 4 significand). A shift loop normalizes one bit per
// cycle, then one rounding step handles significand overflow and saturation.
module fpcvt_seq #(
    parameter bit ROUND_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    fpcvt_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] mag_q, mag_d;
    logic [2:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sign_q, out_sign_d;
    logic [2:0]  out_exp_q, out_exp_d;
    logic [3:0]  out_sig_q, out_sig_d;

    logic        in_ready;
    logic [10:0] neg_low;
    logic [10:0] abs_mag;
    logic [4:0]  sig5;

    // Ready only while idle and out of reset.
    always_comb in_ready = (state_q == IDLE) && !rst;

    // Magnitude of the incoming sample (-2048 clamps to 2047) and rounded significand.
    always_comb begin
        neg_low = 11'd0 - bus.in_data[10:0];
        if (!bus.in_data[11]) begin
            abs_mag = bus.in_data[10:0];
        end else if (bus.in_data[10:0] == '0) begin
            abs_mag = '1;
        end else begin
            abs_mag = neg_low;
        end
        sig5 = {1'b0, mag_q[10:7]} + {4'b0000, (ROUND_EN && mag_q[6])};
    end

    // Next-state and datapath updates for the conversion sequencer.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_sig_d   = out_sig_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    sign_d  = bus.in_data[11];
                    mag_d   = abs_mag;
                    exp_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (mag_q[10] || (exp_q == 3'd0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[9:0], 1'b0};
                    exp_d = exp_q - 3'd1;
                end
            end
            ROUND: begin
                out_sign_d = sign_q;
                if (sig5[4]) begin
                    if (exp_q == 3'd7) begin
                        out_exp_d = 3'd7;
                        out_sig_d = 4'b1111;
                    end else begin
                        out_exp_d = exp_q + 3'd1;
                        out_sig_d = sig5[4:1];
                    end
                end else begin
                    out_exp_d = exp_q;
                    out_sig_d = sig5[3:0];
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_sig_q   <= out_sig_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_sig   = out_sig_q;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Bench for fpcvt_seq: two instances (rounding and truncating) driven in
// lockstep, checked every cycle against a latency-counter reference model.
module tb_fpcvt_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fpcvt_seq_if b1 ();
    fpcvt_seq_if b0 ();

    assign b1.in_valid  = in_valid;
    assign b1.in_data   = in_data;
    assign b1.out_ready = out_ready;
    assign b0.in_valid  = in_valid;
    assign b0.in_data   = in_data;
    assign b0.out_ready = out_ready;

    fpcvt_seq #(.ROUND_EN(1'b1)) dut_rnd (.clk(clk), .rst(rst), .bus(b1));
    fpcvt_seq #(.ROUND_EN(1'b0)) dut_trn (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_mag(input logic [11:0] d);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    // Leading zeros of the 11-bit magnitude, capped at 7.
    function automatic int ref_k(input logic [11:0] d);
        int m, k;
        m = ref_mag(d);
        k = 0;
        while (k < 7 && m < 1024) begin
            m = m * 2;
            k++;
        end
        return k;
    endfunction

    function automatic logic [7:0] ref_cvt(input logic [11:0] d, input bit rnd);
        int m, k, norm, sig, e;
        logic [7:0] r;
        m    = ref_mag(d);
        k    = ref_k(d);
        norm = m * (1 << k);
        sig  = norm / 128;
        if (rnd && ((norm / 64) % 2 == 1)) sig = sig + 1;
        e = 7 - k;
        if (sig == 16) begin
            if (e == 7) sig = 15;
            else begin
                e   = e + 1;
                sig = 8;
            end
        end
        r = {d[11], 3'(e), 4'(sig)};
        return r;
    endfunction

    // Reference model: phase 0 idle, 1 converting (counts k+2 edges), 2 result pending.
    int         phase = 0;
    int         cnt = 0;
    bit         started = 0;
    logic       mv = 1'b0;
    logic [7:0] m1 = '0, m0 = '0, pend1 = '0, pend0 = '0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            phase = 0;
            mv    = 1'b0;
            m1    = '0;
            m0    = '0;
        end else begin
            case (phase)
                0: if (in_valid) begin
                    pend1 = ref_cvt(in_data, 1'b1);
                    pend0 = ref_cvt(in_data, 1'b0);
                    cnt   = ref_k(in_data) + 2;
                    phase = 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        m1    = pend1;
                        m0    = pend0;
                        mv    = 1'b1;
                        phase = 2;
                    end
                end
                default: if (out_ready) begin
                    mv    = 1'b0;
                    phase = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready_rnd",  b1.in_ready,  (phase == 0) && !rst);
            chk("in_ready_trn",  b0.in_ready,  (phase == 0) && !rst);
            chk("out_valid_rnd", b1.out_valid, mv);
            chk("out_valid_trn", b0.out_valid, mv);
            chk("result_rnd", {b1.out_sign, b1.out_exp, b1.out_sig}, m1);
            chk("result_trn", {b0.out_sign, b0.out_exp, b0.out_sig}, m0);
        end
    end

    // One directed conversion; optionally keeps in_valid high with a next
    // sample during a stretch of output backpressure.
    task automatic convert(input logic [11:0] d, input int exp_lat,
                           input logic [7:0] exp1, input logic [7:0] exp0,
                           input int hold, input bit keep, input logic [11:0] next_d,
                           output int waited);
        int lat;
        logic [7:0] cap;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (b1.in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 1, 0);
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = keep;
        in_data  = keep ? next_d : 12'($urandom);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (b1.out_valid) break;
            if (lat > 50) begin
                chk("result_timeout", 1, 0);
                return;
            end
        end
        chk("latency", lat, exp_lat);
        chk("lit_rnd", {b1.out_sign, b1.out_exp, b1.out_sig}, exp1);
        chk("lit_trn", {b0.out_sign, b0.out_exp, b0.out_sig}, exp0);
        cap = {b1.out_sign, b1.out_exp, b1.out_sig};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_in_ready", b1.in_ready, 0);
            chk("bp_valid", b1.out_valid, 1);
            chk("bp_stable", {b1.out_sign, b1.out_exp, b1.out_sig}, cap);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int w;
        logic [11:0] v;

        // Hand-computed values that pin the reference model.
        chk("mdl_0",     ref_cvt(12'h000, 1'b1), 8'h00);
        chk("mdl_1a6",   ref_cvt(12'h1A6, 1'b1), 8'h5D);
        chk("mdl_e5a",   ref_cvt(12'hE5A, 1'b1), 8'hDD);
        chk("mdl_07d_r", ref_cvt(12'h07D, 1'b1), 8'h48);
        chk("mdl_07d_t", ref_cvt(12'h07D, 1'b0), 8'h3F);
        chk("mdl_7ff",   ref_cvt(12'h7FF, 1'b1), 8'h7F);
        chk("mdl_800",   ref_cvt(12'h800, 1'b0), 8'hFF);
        chk("mdl_k_1a6", ref_k(12'h1A6), 2);
        chk("mdl_k_0",   ref_k(12'h000), 7);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases.
        convert(12'h000, 10, 8'h00, 8'h00, 0, 1'b0, 12'h000, w);
        convert(12'h1A6, 5, 8'h5D, 8'h5D, 0, 1'b0, 12'h000, w);
        convert(12'hE5A, 5, 8'hDD, 8'hDD, 0, 1'b0, 12'h000, w);
        convert(12'h7FF, 3, 8'h7F, 8'h7F, 0, 1'b0, 12'h000, w);
        convert(12'h800, 3, 8'hFF, 8'hFF, 0, 1'b0, 12'h000, w);

        // Backpressure with a second sample waiting.
        convert(12'h1A6, 5, 8'h5D, 8'h5D, 6, 1'b1, 12'h07D, w);
        convert(12'h07D, 7, 8'h48, 8'h3F, 0, 1'b0, 12'h000, w);
        chk("accept_after_handshake", w, 0);

        // Reset during SHIFT discards the conversion.
        in_valid = 1'b1;
        in_data  = 12'h001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", b1.out_valid, 0);
        chk("rst_result", {b1.out_sign, b1.out_exp, b1.out_sig}, 0);
        chk("rst_ready", b1.in_ready, 1);
        @(posedge clk); #1;
        convert(12'h1A6, 5, 8'h5D, 8'h5D, 0, 1'b0, 12'h000, w);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            v = 12'($urandom) >> $urandom_range(0, 11);
            if ($urandom_range(0, 1) == 1) v = 12'd0 - v;
            if ($urandom_range(0, 15) == 0) v = 12'h800;
            in_data   = v;
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
